// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: req/gnt/rvalid handshakes of the fetch (0) and load/store (1) ports.
interface ram_port_arbiter_if #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 64
);
    logic                     req0, we0, gnt0, rvalid0;
    logic [ADDRESS_SIZE-1:0]  addr0;
    logic [MEM_WORD_SIZE-1:0] wdata0, rdata0;
    logic                     req1, we1, gnt1, rvalid1;
    logic [ADDRESS_SIZE-1:0]  addr1;
    logic [MEM_WORD_SIZE-1:0] wdata1, rdata1;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
    );
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-port sequencer in front of a single-port RAM with a shared tri-state data bus.
module ram_port_arbiter #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    ram_port_arbiter_if.slave        p,
    output logic [ADDRESS_SIZE-1:0]  ramAddress,
    output logic                     ramIsReading,
    inout  wire  [MEM_WORD_SIZE-1:0] ramData
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     last_q, last_d, win_q, win_d, rd_q, rd_d;
    logic                     gnt0_q, gnt0_d, gnt1_q, gnt1_d, rv0_q, rv0_d, rv1_q, rv1_d;
    logic [ADDRESS_SIZE-1:0]  addr_q, addr_d;
    logic [MEM_WORD_SIZE-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                     pick;

    // On a tie the port that was not granted last wins.
    assign pick = (p.req0 & p.req1) ? ~last_q : p.req1;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        case (state_q)
            IDLE: if (p.req0 | p.req1) begin
                state_d = ACCESS;
                last_d  = pick;
                win_d   = pick;
                addr_d  = pick ? p.addr1 : p.addr0;
                rd_d    = ~(pick ? p.we1 : p.we0);
                wdata_d = pick ? p.wdata1 : p.wdata0;
                gnt0_d  = ~pick;
                gnt1_d  = pick;
            end
            ACCESS: begin
                rd_d    = 1'b1;
                state_d = rd_q ? RESP : IDLE;
            end
            RESP: begin
                state_d  = IDLE;
                rdata0_d = win_q ? rdata0_q : ramData;
                rdata1_d = win_q ? ramData : rdata1_q;
                rv0_d    = ~win_q;
                rv1_d    = win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            rd_q     <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
        end
    end

    // Bus driver and isReading come from the same flop, so the RAM and this block never both drive.
    assign ramData      = rd_q ? 'z : wdata_q;
    assign ramIsReading = rd_q;
    assign ramAddress   = addr_q;
    assign p.gnt0       = gnt0_q;
    assign p.gnt1       = gnt1_q;
    assign p.rvalid0    = rv0_q;
    assign p.rvalid1    = rv1_q;
    assign p.rdata0     = rdata0_q;
    assign p.rdata1     = rdata1_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with a RAM model; expected grant order and read data come from an abstract memory/arbitration model.
module tb_ram_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 64;

    typedef struct { int pt; logic we; logic [AW-1:0] addr; logic [DW-1:0] d; } gexp_t;
    typedef struct { int pt; logic [DW-1:0] d; } rexp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDRESS_SIZE(AW), .MEM_WORD_SIZE(DW)) bus ();
    logic [AW-1:0] ram_address;
    logic          ram_is_reading;
    wire  [DW-1:0] ram_data;

    ram_port_arbiter #(.ADDRESS_SIZE(AW), .MEM_WORD_SIZE(DW)) dut (
        .clk(clk), .reset(reset), .p(bus),
        .ramAddress(ram_address), .ramIsReading(ram_is_reading), .ramData(ram_data)
    );

    // RAM: writes when isReading is low, otherwise latches the addressed word and drives it next cycle.
    logic [DW-1:0] mem [2**AW] = '{default: '0};
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (!ram_is_reading) mem[ram_address] <= ram_data;
        else ram_q <= mem[ram_address];
    end
    assign ram_data = ram_is_reading ? ram_q : 'z;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_cyc = -100;
    logic last = 1'b1;
    logic [DW-1:0] prev0, prev1;
    logic [DW-1:0] model [logic [AW-1:0]];
    gexp_t gq[$];
    rexp_t rq[$];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        return model.exists(a) ? model[a] : '0;
    endfunction

    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        cyc++;
        if (reset) begin
            prev0 = bus.rdata0;
            prev1 = bus.rdata1;
        end else begin
            if (bus.gnt0 | bus.gnt1) begin
                chk("gnt_both", 64'(bus.gnt0 & bus.gnt1), 64'(0));
                if (gq.size() == 0) chk("unexpected_gnt", 64'(bus.gnt0 | bus.gnt1), 64'(0));
                else begin
                    g = gq.pop_front();
                    chk("gnt_port", 64'(bus.gnt1), 64'(g.pt));
                    chk("gnt_addr", 64'(ram_address), 64'(g.addr));
                    chk("gnt_isreading", 64'(ram_is_reading), 64'(!g.we));
                    if (g.we) chk("wr_bus", ram_data, g.d);
                    else rd_cyc = cyc;
                end
            end else chk("idle_isreading", 64'(ram_is_reading), 64'(1));
            if (bus.rvalid0 | bus.rvalid1) begin
                chk("rvalid_both", 64'(bus.rvalid0 & bus.rvalid1), 64'(0));
                if (rq.size() == 0) chk("unexpected_rvalid", 64'(bus.rvalid0 | bus.rvalid1), 64'(0));
                else begin
                    r = rq.pop_front();
                    chk("rvalid_port", 64'(bus.rvalid1), 64'(r.pt));
                    chk("rdata", bus.rvalid1 ? bus.rdata1 : bus.rdata0, r.d);
                    chk("rvalid_latency", 64'(cyc - rd_cyc), 64'(2));
                end
            end
            if (!bus.rvalid0) chk("rdata0_hold", bus.rdata0, prev0);
            if (!bus.rvalid1) chk("rdata1_hold", bus.rdata1, prev1);
            prev0 = bus.rdata0;
            prev1 = bus.rdata1;
        end
    end

    task automatic drive(input int pt, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (pt == 0) begin bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
        else begin bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    endtask

    function automatic logic gnt_of(input int pt);
        return pt == 0 ? bus.gnt0 : bus.gnt1;
    endfunction

    task automatic wait_gnt(input int pt, input bit keep, output int waited);
        waited = 0;
        do begin @(negedge clk); waited++; end while (!gnt_of(pt) && waited < 40);
        if (!gnt_of(pt)) chk($sformatf("gnt%0d_timeout", pt), 64'(gnt_of(pt)), 64'(1));
        if (!keep) begin
            if (pt == 0) bus.req0 = 1'b0;
            else bus.req1 = 1'b0;
        end
    endtask

    task automatic expect_txn(input int pt, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit resp);
        gq.push_back('{pt, w, a, d});
        if (w) model[a] = d;
        else if (resp) rq.push_back('{pt, mread(a)});
        last = pt[0];
    endtask

    task automatic round(input logic [1:0] mask, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int first, wt0, wt1;
        first = mask == 2'b11 ? int'(!last) : (mask == 2'b10 ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            int q = first ^ k;
            if (mask[q]) expect_txn(q, q ? w1 : w0, q ? a1 : a0, q ? d1 : d0, 1'b1);
        end
        fork
            begin if (mask[0]) begin drive(0, 1'b1, w0, a0, d0); wait_gnt(0, 1'b0, wt0); end end
            begin if (mask[1]) begin drive(1, 1'b1, w1, a1, d1); wait_gnt(1, 1'b0, wt1); end end
        join
        repeat (4) @(negedge clk);
    endtask

    task automatic sat_port(input int pt, input logic [AW-1:0] a, input int n);
        int wt;
        for (int k = 0; k < n; k++) begin
            drive(pt, 1'b1, 1'b0, a, '0);
            wait_gnt(pt, 1'b0, wt);
            @(negedge clk);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int s = $urandom_range(0, 4);
        return s == 0 ? AW'(0) : s == 1 ? AW'(5) : s == 2 ? AW'('h10) : s == 3 ? AW'('h7FF) : AW'($urandom);
    endfunction

    initial begin
        int wt, first;
        logic [DW-1:0] bd [4];
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_isreading", 64'(ram_is_reading), 64'(1));
        chk("rst_addr", 64'(ram_address), 64'(0));
        chk("rst_gnt", 64'({bus.gnt0, bus.gnt1}), 64'(0));
        chk("rst_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'(0));
        chk("rst_rdata0", bus.rdata0, '0);
        chk("rst_rdata1", bus.rdata1, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        round(2'b11, 1'b0, 'h10, '0, 1'b1, 'h10, 64'h1234);
        round(2'b10, 1'b0, '0, '0, 1'b1, 'h05, 64'hDEADBEEF_00000001);
        round(2'b10, 1'b0, '0, '0, 1'b0, 'h05, '0);
        chk("rdata0_untouched", bus.rdata0, '0);
        round(2'b01, 1'b0, 'h10, '0, 1'b0, '0, '0);
        round(2'b01, 1'b1, 'h7FF, 64'hA5A5_0000_FFFF_7FF0, 1'b0, '0, '0);

        first = int'(!last);
        for (int i = 0; i < 8; i++) expect_txn(first ^ (i & 1), 1'b0, (first ^ (i & 1)) ? AW'(0) : AW'('h7FF), '0, 1'b1);
        fork
            sat_port(0, 'h7FF, 4);
            sat_port(1, '0, 4);
        join
        repeat (4) @(negedge clk);

        drive(0, 1'b1, 1'b0, 'h10, '0);
        expect_txn(0, 1'b0, 'h10, '0, 1'b0);
        wait_gnt(0, 1'b0, wt);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_isreading", 64'(ram_is_reading), 64'(1));
        chk("midrst_rvalid0", 64'(bus.rvalid0), 64'(0));
        chk("midrst_rdata0", bus.rdata0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last = 1'b1;
        repeat (3) @(negedge clk);
        round(2'b01, 1'b0, 'h10, '0, 1'b0, '0, '0);
        round(2'b11, 1'b0, 'h05, '0, 1'b0, 'h10, '0);

        for (int k = 0; k < 4; k++) begin
            bd[k] = {$urandom, $urandom};
            expect_txn(1, 1'b1, AW'(k), bd[k], 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, 1'b1, AW'(k), bd[k]);
            wait_gnt(1, 1'b1, wt);
            chk("b2b_spacing", 64'(wt), k == 0 ? 64'(1) : 64'(2));
        end
        bus.req1 = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) round(2'b01, 1'b0, AW'(k), '0, 1'b0, '0, '0);

        for (int i = 0; i < 60; i++)
            round(2'($urandom_range(1, 3)), 1'($urandom), rnd_addr(), {$urandom, $urandom},
                  1'($urandom), rnd_addr(), {$urandom, $urandom});

        repeat (5) @(negedge clk);
        chk("gnt_queue_drained", 64'(gq.size()), 64'(0));
        chk("rsp_queue_drained", 64'(rq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
